// File: rtl/parity_frame_scheduler_if.sv
// Bus bundle for parity_frame_scheduler: two requester handshakes, the shared checker link and the verdict.
// err_count is present only when PARITY_ERR_CNT_EN is defined.
interface parity_frame_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_pbit;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_pbit;
  logic             req1_ready;
  logic             pc_x;
  logic             pc_even_odd;
  logic             done;
  logic             done_id;
  logic             parity_err;
`ifdef PARITY_ERR_CNT_EN
  logic [15:0]      err_count;

  modport master (
    input  req0_valid, req0_data, req0_pbit,
    output req0_ready,
    input  req1_valid, req1_data, req1_pbit,
    output req1_ready,
    output pc_x,
    input  pc_even_odd,
    output done, done_id, parity_err,
    output err_count
  );

  modport slave (
    output req0_valid, req0_data, req0_pbit,
    input  req0_ready,
    output req1_valid, req1_data, req1_pbit,
    input  req1_ready,
    input  pc_x,
    output pc_even_odd,
    input  done, done_id, parity_err,
    input  err_count
  );
`else
  modport master (
    input  req0_valid, req0_data, req0_pbit,
    output req0_ready,
    input  req1_valid, req1_data, req1_pbit,
    output req1_ready,
    output pc_x,
    input  pc_even_odd,
    output done, done_id, parity_err
  );

  modport slave (
    output req0_valid, req0_data, req0_pbit,
    input  req0_ready,
    output req1_valid, req1_data, req1_pbit,
    input  req1_ready,
    input  pc_x,
    output pc_even_odd,
    input  done, done_id, parity_err
  );
`endif
endinterface

// File: rtl/parity_frame_scheduler.sv
// Round-robin sharing of one serial parity checker between two word requesters; verdict by checker-state delta.
// Optional saturating parity-error counter enabled with `define PARITY_ERR_CNT_EN.
module parity_frame_scheduler #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  parity_frame_scheduler_if.master bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;
  logic             pc_x_q;
  logic             done_q;
  logic             done_id_q;
  logic             parity_err_q;

  logic [WIDTH-2:0] shreg_q;
  logic             pbit_q;
  logic             base_q;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_pbit;
  logic             err_d;

  // Grant is only offered in IDLE and never while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && reset_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign accept   = grant0 | grant1;
  assign sel_data = grant1 ? bus.req1_data : bus.req0_data;
  assign sel_pbit = grant1 ? bus.req1_pbit : bus.req0_pbit;

  // Checker state delta over the frame is the ones-parity, whatever the checker held before.
  assign err_d = bus.pc_even_odd ^ base_q ^ pbit_q ^ ODD;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      pc_x_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= SHIFT;
            cnt_q        <= '0;
            last_grant_q <= grant1;
            pc_x_q       <= sel_data[0];
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= CHECK;
            pc_x_q  <= 1'b0;
          end else begin
            pc_x_q  <= shreg_q[0];
          end
        end
        CHECK: begin
          state_q      <= IDLE;
          done_q       <= 1'b1;
          done_id_q    <= last_grant_q;
          parity_err_q <= err_d;
        end
        default: begin
          state_q <= IDLE;
          pc_x_q  <= 1'b0;
        end
      endcase
    end
  end

  // Frame payload: captured at accept, shifted while serialising; no reset needed.
  always_ff @(posedge clock) begin
    if (accept) begin
      shreg_q <= sel_data[WIDTH-1:1];
      pbit_q  <= sel_pbit;
      base_q  <= bus.pc_even_odd;
    end else if (state_q == SHIFT) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.pc_x       = pc_x_q;
  assign bus.done       = done_q;
  assign bus.done_id    = done_id_q;
  assign bus.parity_err = parity_err_q;

`ifdef PARITY_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (done_q && parity_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// Scoreboard bench for parity_frame_scheduler (WIDTH=8, ODD=0) with a behavioural serial parity checker.
// Build with PARITY_ERR_CNT_EN defined to also exercise the error counter.
module tb_parity_frame_scheduler;

  logic clock = 1'b0;
  logic reset_n;
  logic eo = 1'b0;
  logic ext_x = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic id;
    logic err;
    int   acc;
  } exp_t;

  exp_t sb[$];

  parity_frame_scheduler_if #(.WIDTH(8)) bus ();

  parity_frame_scheduler #(.WIDTH(8), .ODD(1'b0)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Shared checker: toggles on x=1, never cleared.
  always @(posedge clock) eo <= eo ^ (bus.pc_x | ext_x);
  assign bus.pc_even_odd = eo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending frame", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_id", 32'(bus.done_id), 32'(e.id));
        chk("parity_err", 32'(bus.parity_err), 32'(e.err));
        chk("done_latency", 32'(cyc - e.acc), 32'd10);
      end
    end
  end

  // Called at a negedge; returns 1ns after the accept edge with the requester's inputs scrambled.
  task automatic send(input bit id, input logic [7:0] d, input logic p, input logic e,
                      input bit expect_done);
    int n;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_pbit = p;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_pbit = p;
    end
    #1;
    n = 0;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no ready for req%0d expected ready within 50 cycles", id);
    end else if (expect_done) begin
      sb.push_back('{id: id, err: e, acc: cyc});
    end
    @(posedge clock); #1;
    if (id) begin
      bus.req1_valid = 1'b0; bus.req1_data = ~d; bus.req1_pbit = ~p;
    end else begin
      bus.req0_valid = 1'b0; bus.req0_data = ~d; bus.req0_pbit = ~p;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got %0d pending frames expected 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] a5;
    int seen, rdy_cycles, last_acc, n;

    reset_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h3C; bus.req0_pbit = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 8'hC3; bus.req1_pbit = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_pc_x", 32'(bus.pc_x), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_done_id", 32'(bus.done_id), 32'd0);
    chk("rst_parity_err", 32'(bus.parity_err), 32'd0);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // req0 0xA5: serial order LSB first; a short req1 request during SHIFT must be ignored.
    a5 = 8'hA5;
    send(1'b0, a5, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk($sformatf("pc_x_bit%0d", k), 32'(bus.pc_x), 32'(a5[k]));
      bus.req1_valid = (k == 2 || k == 3);
    end
    bus.req1_valid = 1'b0;
    wait_idle();
    chk("idle_pc_x", 32'(bus.pc_x), 32'd0);

    send(1'b1, 8'h07, 1'b0, 1'b1, 1'b1);
    wait_idle();
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Both requesters held valid: alternate grants, back-to-back frames.
    bus.req0_valid = 1'b1; bus.req0_data = 8'h03; bus.req0_pbit = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h01; bus.req1_pbit = 1'b0;
    seen = 0; rdy_cycles = 0; last_acc = 0; n = 0;
    while (seen < 4 && n < 100) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) begin
        tests++; fails++;
        $display("FAIL rr_both_ready: got both readies high expected one");
      end
      if (bus.req0_ready || bus.req1_ready) begin
        rdy_cycles++;
        chk("rr_grant_id", 32'(bus.req1_ready), 32'(seen % 2));
        if (seen > 0) chk("rr_spacing", 32'(cyc - last_acc), 32'd10);
        sb.push_back('{id: bus.req1_ready, err: bus.req1_ready, acc: cyc});
        last_acc = cyc;
        seen++;
      end
      @(negedge clock);
      n++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rr_frames", 32'(seen), 32'd4);
    chk("rr_ready_cycles", 32'(rdy_cycles), 32'd4);
    wait_idle();

    // Put the checker in the odd state from outside before the frame.
    n = 0;
    while (eo !== 1'b1 && n < 3) begin
      ext_x = 1'b1;
      @(negedge clock);
      ext_x = 1'b0;
      n++;
    end
    chk("pretoggle_odd", 32'(eo), 32'd1);
    send(1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Reset during SHIFT bit 3 (the 1 in 0x08) kills the frame.
    send(1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_pc_x", 32'(bus.pc_x), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (14) @(negedge clock);
    send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_idle();

`ifdef PARITY_ERR_CNT_EN
    send(1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
    send(1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
    send(1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
    send(1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
    wait_idle();
    @(negedge clock);
    chk("err_count_3", 32'(bus.err_count), 32'd3);
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.err_cnt_q;
    send(1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
    wait_idle();
    @(negedge clock);
    chk("err_count_sat", 32'(bus.err_count), 32'h0000FFFF);
`endif

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
